exec_unit_cdb: RTL and testbench
================================

// Module: exec_unit_cdb
// PURPOSE
//  Unary functional unit at the consumer end of an issue queue (reservation station).
//  Accepts issued entries (op, operand, destination tag) under a valid/ready handshake.
//  Executes over a fixed LATENCY and buffers results in order.
//  Broadcasts each result once on the common data bus (BCEN/BClabel/BCdata) after the CDB arbiter grants it.
// PARAMETERS
//  LATENCY     2   execute pipeline depth in cycles, 1..4
//  RBUF_DEPTH  4   result buffer entries, power of two, 2..8
//  TAG_W       5   tag width; tag 0 = "no tag / value ready", never broadcast
// PORTS
//  clk         in   1      clock, all state on posedge
//  nRST        in   1      asynchronous active-low reset
//  require     in   1      issue valid: queue head operand ready
//  requireAC   out  1      issue ready: unit can accept this cycle
//  opIN        in   1      operation: `OP_MOV=0 (pass), `OP_NEG=1 (two's-complement negate)
//  dataIn      in   32     operand
//  labelIn     in   TAG_W  destination tag (id label of the issuing entry)
//  cdbReq      out  1      request for the CDB; high whenever the result buffer is non-empty
//  cdbGrant    in   1      arbiter grant; meaningful only when cdbReq=1
//  BCEN        out  1      broadcast enable, one-cycle pulse per result
//  BClabel     out  TAG_W  broadcast tag
//  BCdata      out  32     broadcast value
// BEHAVIOUR
//  Reset (async, nRST=0): pipeline valids=0; buffer empty; BCEN=0; BClabel=0; BCdata=0.
//   Under reset cdbReq=0 and requireAC=1.
//  Issue: fire = require & requireAC. Captures opIN/dataIn/labelIn into stage 1 at posedge.
//  requireAC = (bufCount + pipeValidCount) < RBUF_DEPTH (credit scheme, combinational).
//   A buffer pop in cycle N frees a credit from cycle N+1, not the same cycle.
//  require=1 with labelIn=0 is a protocol error. It is not accepted: requireAC is forced 0 for it.
//   Credits do not change.
//  Execute: result is computed in stage 1, then shifted through LATENCY stages.
//   MOV: res=dataIn. NEG: res=~dataIn+1, 32-bit wrap, so NEG 0x80000000 = 0x80000000.
//   Valid and tag travel alongside res.
//   Entry issued at posedge N is written to the buffer at posedge N+LATENCY.
//  Result buffer: FIFO, strictly in issue order.
//   Simultaneous push and pop is allowed at any count, including full and empty.
//   Overflow is impossible by credit. Pointers wrap modulo RBUF_DEPTH.
//  Broadcast: cdbReq = !empty (combinational).
//   On a posedge with cdbReq & cdbGrant, the head is popped.
//   BCEN=1, BClabel=head.tag, BCdata=head.res are registered in the same edge.
//   Next edge returns BCEN=0, with BClabel/BCdata cleared to 0.
//   Minimum issue-to-BCEN latency = LATENCY+1 cycles with grant held high.
//   A back-to-back grant gives one broadcast per cycle.
//  Grant while empty: ignored, BCEN stays 0.
//  Grant removed while requesting: entry is held and cdbReq stays high, with no timeout.
//  Reset mid-operation: every in-flight and buffered result is discarded; none is broadcast.
// STRUCTURE
//  head.v: `OP_MOV, `OP_NEG, `TAG_NONE(0) defines; reuse existing `QUE0..`QUE2 tag values in benches.
//  Sub-module result_fifo (params DEPTH, W): push/pop/empty/count, async active-low reset.
//   Instantiated once with W=TAG_W+32.
//  Top level holds the issue credit logic, the LATENCY-stage shift pipeline (generate loop)
//   and the broadcast output register.
// TESTING
//  1 Reset: nRST=0 mid-stream -> BCEN=0, cdbReq=0, requireAC=1.
//    After release, no stale broadcast within 20 cycles.
//  2 Single op: issue MOV 0x12345678 tag `QUE1 with grant=1 -> BCEN=1 at cycle 3,
//    BClabel=`QUE1, BCdata=0x12345678.
//  3 NEG cases: issue NEG 5 -> BCdata=0xFFFFFFFB; NEG 0 -> 0; NEG 0x80000000 -> 0x80000000.
//  4 Backpressure: hold grant=0 and issue continuously -> exactly 4 accepted, then requireAC=0.
//    Raise grant -> 4 BCEN pulses in issue order on 4 consecutive cycles.
//    requireAC returns 1 on the cycle after the first pop.
//  5 Full and simultaneous: with buffer at 3 and one in flight, pulse grant and issue together ->
//    count stays consistent; no drop, no duplicate tag.
//  6 Illegal tag: require=1, labelIn=0 -> requireAC=0; no broadcast produced; credits unchanged.

Source files
------------

// File: rtl/exec_unit_cdb_pkg.sv
// Shared opcodes and execute helper
// for the CDB-broadcasting unary unit.
package exec_unit_cdb_pkg;

   localparam logic OP_MOV = 1'b0;
   localparam logic OP_NEG = 1'b1;
   localparam int   DATA_W = 32;

   function automatic logic [DATA_W-1:0] alu_f(
      input logic              op,
      input logic [DATA_W-1:0] a
   );
      return (op == OP_NEG) ? (~a + 32'd1) : a;
   endfunction

endpackage

// File: rtl/exec_unit_cdb_result_fifo.sv
// In-order result buffer feeding the CDB.
// Push and pop may coincide at any fill level.
import exec_unit_cdb_pkg::*;

module result_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 37,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // pointer and occupancy update
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // pointer/count state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // storage, no reset needed
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/exec_unit_cdb.sv
// Unary execute unit: credit-gated issue,
// fixed-latency pipe, in-order CDB broadcast.
import exec_unit_cdb_pkg::*;

module exec_unit_cdb #(
   parameter int LATENCY    = 2,
   parameter int RBUF_DEPTH = 4,
   parameter int TAG_W      = 5
) (
   input  logic              clk,
   input  logic              nRST,
   input  logic              require,
   output logic              requireAC,
   input  logic              opIN,
   input  logic [31:0]       dataIn,
   input  logic [TAG_W-1:0]  labelIn,
   output logic              cdbReq,
   input  logic              cdbGrant,
   output logic              BCEN,
   output logic [TAG_W-1:0]  BClabel,
   output logic [31:0]       BCdata
);

   localparam int CW = $clog2(RBUF_DEPTH + 1);
   localparam int SW = CW + 1;
   localparam int FW = TAG_W + 32;

   logic              vld_q [LATENCY];
   logic [TAG_W-1:0]  tag_q [LATENCY];
   logic [31:0]       res_q [LATENCY];

   logic              fire;
   logic              push;
   logic              pop;
   logic              empty;
   logic [CW-1:0]     buf_cnt;
   logic [SW-1:0]     pipe_cnt;
   logic [SW-1:0]     used;
   logic [FW-1:0]     head;

   // entries in flight through the pipe
   always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < LATENCY; i++) begin
         pipe_cnt = pipe_cnt + SW'(vld_q[i]);
      end
   end

   // credits: an untagged request is never taken
   always_comb begin
      used      = SW'(buf_cnt) + pipe_cnt;
      requireAC = (used < SW'(RBUF_DEPTH)) &&
                  !(require && (labelIn == '0));
   end

   assign fire   = require & requireAC;
   assign push   = vld_q[LATENCY-1];
   assign cdbReq = !empty;
   assign pop    = cdbReq & cdbGrant;

   for (genvar g = 0; g < LATENCY; g++) begin : g_pipe
      if (g == 0) begin : g_head
         // stage 1 computes the result
         always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
               vld_q[0] <= 1'b0;
               tag_q[0] <= '0;
               res_q[0] <= '0;
            end else begin
               vld_q[0] <= fire;
               tag_q[0] <= labelIn;
               res_q[0] <= alu_f(opIN, dataIn);
            end
         end
      end else begin : g_shift
         // later stages only carry the result
         always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
               vld_q[g] <= 1'b0;
               tag_q[g] <= '0;
               res_q[g] <= '0;
            end else begin
               vld_q[g] <= vld_q[g-1];
               tag_q[g] <= tag_q[g-1];
               res_q[g] <= res_q[g-1];
            end
         end
      end
   end

   result_fifo #(
      .DEPTH (RBUF_DEPTH),
      .W     (FW),
      .CW    (CW)
   ) u_rbuf (
      .clk     (clk),
      .rst_n   (nRST),
      .push_i  (push),
      .wdata_i ({tag_q[LATENCY-1], res_q[LATENCY-1]}),
      .pop_i   (pop),
      .rdata_o (head),
      .empty_o (empty),
      .count_o (buf_cnt)
   );

   // one-cycle broadcast of the popped head
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         BCEN    <= 1'b0;
         BClabel <= '0;
         BCdata  <= '0;
      end else if (pop) begin
         BCEN    <= 1'b1;
         BClabel <= head[FW-1:32];
         BCdata  <= head[31:0];
      end else begin
         BCEN    <= 1'b0;
         BClabel <= '0;
         BCdata  <= '0;
      end
   end

endmodule

// File: tb/tb_exec_unit_cdb.sv
// Scoreboard bench for exec_unit_cdb:
// random issue/grant vs. a credit/queue model.
module tb_exec_unit_cdb;

   localparam int LAT  = 2;
   localparam int DEP  = 4;
   localparam int TW   = 5;
   localparam logic [TW-1:0] QUE0 = 5'd1;
   localparam logic [TW-1:0] QUE1 = 5'd2;
   localparam logic [TW-1:0] QUE2 = 5'd3;

   logic          clk = 1'b0;
   logic          nRST = 1'b0;
   logic          require = 1'b0;
   logic          requireAC;
   logic          opIN = 1'b0;
   logic [31:0]   dataIn = '0;
   logic [TW-1:0] labelIn = '0;
   logic          cdbReq;
   logic          cdbGrant = 1'b0;
   logic          BCEN;
   logic [TW-1:0] BClabel;
   logic [31:0]   BCdata;

   int checks = 0;
   int errors = 0;
   int acc = 0;
   int bcn = 0;
   logic [TW+31:0] sbq [$];

   exec_unit_cdb #(
      .LATENCY    (LAT),
      .RBUF_DEPTH (DEP),
      .TAG_W      (TW)
   ) dut (
      .clk       (clk),
      .nRST      (nRST),
      .require   (require),
      .requireAC (requireAC),
      .opIN      (opIN),
      .dataIn    (dataIn),
      .labelIn   (labelIn),
      .cdbReq    (cdbReq),
      .cdbGrant  (cdbGrant),
      .BCEN      (BCEN),
      .BClabel   (BClabel),
      .BCdata    (BCdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic op,
                                         input logic [31:0] d);
      logic [31:0] z;
      z = 32'd0;
      return op ? (z - d) : d;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: every broadcast must be the oldest expected result
   always @(negedge clk) begin
      if (nRST) begin
         if (BCEN) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bc_unexpected: got tag %0h data %0h expected none",
                        BClabel, BCdata);
            end else begin
               logic [TW+31:0] e;
               e = sbq.pop_front();
               chk("bc_tag", 64'(BClabel), 64'(e[TW+31:32]));
               chk("bc_data", 64'(BCdata), 64'(e[31:0]));
            end
            bcn++;
         end else begin
            chk("bc_idle", {27'd0, BClabel, BCdata}, 64'd0);
         end
      end
   end

   // one cycle of stimulus plus credit check against the model
   task automatic step(input logic rq, input logic op,
                       input logic [31:0] d, input logic [TW-1:0] lb,
                       input logic gr);
      logic exp_ac;
      @(posedge clk);
      #1;
      require  = rq;
      opIN     = op;
      dataIn   = d;
      labelIn  = lb;
      cdbGrant = gr;
      @(negedge clk);
      #1;
      exp_ac = ((acc - bcn) < DEP) && !(rq && (lb == '0));
      chk("requireAC", 64'(requireAC), 64'(exp_ac));
      if (rq && requireAC) begin
         sbq.push_back({lb, model(op, d)});
         acc++;
      end
   endtask

   task automatic idle(input logic gr);
      step(1'b0, 1'b0, 32'd0, '0, gr);
   endtask

   initial begin
      int a0;
      logic [31:0] d;
      repeat (3) @(posedge clk);
      #2 nRST = 1'b1;
      #1;
      chk("rst_bcen", 64'(BCEN), 64'd0);
      chk("rst_cdbreq", 64'(cdbReq), 64'd0);
      chk("rst_reqac", 64'(requireAC), 64'd1);

      // single MOV: broadcast on the third edge after the fire edge
      step(1'b1, 1'b0, 32'h12345678, QUE1, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         idle(1'b1);
         chk("lat_bcen", 64'(BCEN), 64'(i == 4));
      end
      chk("lat_tag", 64'(BClabel), 64'(QUE1));
      chk("lat_data", 64'(BCdata), 64'h12345678);

      // negate corner values
      step(1'b1, 1'b1, 32'd5, QUE0, 1'b1);
      step(1'b1, 1'b1, 32'd0, QUE1, 1'b1);
      step(1'b1, 1'b1, 32'h80000000, QUE2, 1'b1);
      repeat (6) idle(1'b1);
      chk("neg_drained", 64'(sbq.size()), 64'd0);

      // backpressure: only DEP entries accepted
      a0 = acc;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'($urandom), $urandom, TW'(i + 1), 1'b0);
      end
      chk("bp_accepted", 64'(acc - a0), 64'(DEP));
      chk("bp_cdbreq", 64'(cdbReq), 64'd1);
      for (int i = 0; i < 6; i++) begin
         idle(1'b1);
         chk("bp_burst", 64'(BCEN), 64'(i >= 1 && i <= 4));
      end

      // fill buffer to 3 with one in flight, then grant and issue together
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 32'h100 + i, TW'(10 + i), 1'b0);
      end
      step(1'b1, 1'b1, 32'h200, 5'd20, 1'b1);
      step(1'b1, 1'b0, 32'h201, 5'd21, 1'b0);
      step(1'b1, 1'b1, 32'h202, 5'd22, 1'b1);
      repeat (12) idle(1'b1);
      chk("full_drained", 64'(sbq.size()), 64'd0);

      // untagged request is refused and changes nothing
      a0 = acc;
      repeat (3) step(1'b1, 1'b1, 32'hDEAD, '0, 1'b1);
      repeat (4) idle(1'b1);
      chk("illegal_acc", 64'(acc - a0), 64'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 4))
            0:       d = 32'h80000000;
            1:       d = 32'd0;
            default: d = $urandom;
         endcase
         step(($urandom_range(0, 9) < 7), 1'($urandom), d,
              ($urandom_range(0, 15) == 0) ? '0 : TW'($urandom),
              ($urandom_range(0, 9) < 6));
      end
      for (int n = 0; n < 40 && sbq.size() != 0; n++) idle(1'b1);
      idle(1'b1);
      chk("rand_drained", 64'(sbq.size()), 64'd0);
      chk("rand_cdbreq", 64'(cdbReq), 64'd0);

      // reset with work in flight and buffered
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 32'h300 + i, TW'(i + 1), 1'b0);
      end
      @(posedge clk);
      #3;
      require = 1'b0;
      nRST    = 1'b0;
      #1;
      chk("mid_rst_bcen", 64'(BCEN), 64'd0);
      chk("mid_rst_cdbreq", 64'(cdbReq), 64'd0);
      chk("mid_rst_reqac", 64'(requireAC), 64'd1);
      sbq.delete();
      acc = 0;
      bcn = 0;
      @(negedge clk);
      #2 nRST = 1'b1;
      repeat (20) idle(1'b1);
      chk("post_rst_cdbreq", 64'(cdbReq), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
